lsu_mshq: RTL and testbench

Miss Status Holding Queue for the LSU data cache, directly downstream of the store queue and the LSU hit stage. It accepts D$ misses from retired stores and from loads, merges misses to the same cache line, issues one line-fill request per entry to memory, and writes the filled line, with store bytes merged over it, into the D$. Its full and retry outputs feed the store queue's retire stall (`i_sq_retire_mshq_full`).

---
 rtl/lsu_mshq_if.sv | 48 ++++
 rtl/lsu_mshq.sv | 194 +++++++++++++++++++
 tb/tb_lsu_mshq.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mshq_if.sv
// Miss allocate, line-fill request/return and D$ fill write bundle for lsu_mshq.
// Master is the LSU/memory side that drives the i_* signals; slave is the queue itself.
interface lsu_mshq_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DC_LINE_SIZE   = 32,
    parameter int MSHQ_TAG_WIDTH = 2
);
    logic                      i_alloc_en;
    logic                      i_alloc_store;
    logic [ADDR_WIDTH-1:0]     i_alloc_addr;
    logic [DATA_WIDTH-1:0]     i_alloc_data;
    logic [3:0]                i_alloc_width;
    logic                      o_full;
    logic                      o_retry;

    logic                      o_mem_req_valid;
    logic [ADDR_WIDTH-1:0]     o_mem_req_addr;
    logic [MSHQ_TAG_WIDTH-1:0] o_mem_req_tag;
    logic                      i_mem_req_ready;

    logic                      i_mem_fill_valid;
    logic [MSHQ_TAG_WIDTH-1:0] i_mem_fill_tag;
    logic [DC_LINE_SIZE*8-1:0] i_mem_fill_data;

    logic                      o_fill_en;
    logic [ADDR_WIDTH-1:0]     o_fill_addr;
    logic [DC_LINE_SIZE*8-1:0] o_fill_data;
    logic                      o_fill_dirty;

    modport master (
        output i_alloc_en, i_alloc_store, i_alloc_addr, i_alloc_data, i_alloc_width,
        input  o_full, o_retry,
        input  o_mem_req_valid, o_mem_req_addr, o_mem_req_tag,
        output i_mem_req_ready,
        output i_mem_fill_valid, i_mem_fill_tag, i_mem_fill_data,
        input  o_fill_en, o_fill_addr, o_fill_data, o_fill_dirty
    );

    modport slave (
        input  i_alloc_en, i_alloc_store, i_alloc_addr, i_alloc_data, i_alloc_width,
        output o_full, o_retry,
        output o_mem_req_valid, o_mem_req_addr, o_mem_req_tag,
        input  i_mem_req_ready,
        input  i_mem_fill_valid, i_mem_fill_tag, i_mem_fill_data,
        output o_fill_en, o_fill_addr, o_fill_data, o_fill_dirty
    );
endinterface

// File: rtl/lsu_mshq.sv
// D$ miss status holding queue: merges misses per line, issues line fills, writes merged lines to D$.
// Latency: request the cycle after allocate; D$ write (o_fill_*) registered 1 cycle after fill capture.
// Backpressure: o_full/o_retry stall upstream; requests hold stable until i_mem_req_ready. Macro: LSU_MSHQ_STORE_MERGE_EN.
module lsu_mshq #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int DC_LINE_SIZE   = 32,
    parameter int MSHQ_DEPTH     = 4,
    parameter int MSHQ_TAG_WIDTH = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    lsu_mshq_if.slave   bus
);

    localparam int LINE_W     = DC_LINE_SIZE * 8;
    localparam int OFF_W      = $clog2(DC_LINE_SIZE);
    localparam int WORD_BYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_INFLT, ST_DONE} ent_state_t;
    typedef logic [MSHQ_TAG_WIDTH-1:0] tag_t;

    ent_state_t                e_state [MSHQ_DEPTH];
    logic [ADDR_WIDTH-1:0]     e_addr  [MSHQ_DEPTH];
    logic [LINE_W-1:0]         e_data  [MSHQ_DEPTH];
    logic [DC_LINE_SIZE-1:0]   e_mask  [MSHQ_DEPTH];
    logic                      e_dirty [MSHQ_DEPTH];

    logic                      req_hold;
    tag_t                      req_hold_idx;

    function automatic logic [LINE_W-1:0] byte_merge(
        input logic [LINE_W-1:0]       base,
        input logic [LINE_W-1:0]       over,
        input logic [DC_LINE_SIZE-1:0] sel
    );
        logic [LINE_W-1:0] r;
        r = base;
        for (int b = 0; b < DC_LINE_SIZE; b++) begin
            if (sel[b]) r[8*b +: 8] = over[8*b +: 8];
        end
        return r;
    endfunction

    // Store word placed at its position inside the line
    logic                      alloc_store;
    logic [ADDR_WIDTH-1:0]     line_addr;
    logic [OFF_W-1:0]          word_off;
    logic [DC_LINE_SIZE-1:0]   st_mask;
    logic [LINE_W-1:0]         st_data;

    assign alloc_store = bus.i_alloc_en & bus.i_alloc_store;
    assign line_addr   = bus.i_alloc_addr & ~ADDR_WIDTH'(DC_LINE_SIZE - 1);
    assign word_off    = bus.i_alloc_addr[OFF_W-1:0] & ~OFF_W'(WORD_BYTES - 1);
    assign st_mask     = alloc_store ? (DC_LINE_SIZE'(bus.i_alloc_width) << word_off) : '0;
    assign st_data     = alloc_store ? (LINE_W'(bus.i_alloc_data) << {word_off, 3'b000}) : '0;

    logic match_any;
    tag_t match_idx;
    logic has_free;
    tag_t free_idx;
    logic has_pend;
    tag_t pend_idx;

    // Descending scan so the lowest index wins each search
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        has_free  = 1'b0;
        free_idx  = '0;
        has_pend  = 1'b0;
        pend_idx  = '0;
        for (int i = MSHQ_DEPTH - 1; i >= 0; i--) begin
            if (e_state[i] != ST_FREE && e_addr[i] == line_addr) begin
                match_any = 1'b1;
                match_idx = tag_t'(i);
            end
            if (e_state[i] == ST_FREE) begin
                has_free = 1'b1;
                free_idx = tag_t'(i);
            end
            if (e_state[i] == ST_PEND) begin
                has_pend = 1'b1;
                pend_idx = tag_t'(i);
            end
        end
    end

    logic match_done;
    logic match_busy;
    logic merge_en;
    logic store_block;
    logic alloc_new;

    assign match_done = match_any & (e_state[match_idx] == ST_DONE);
    assign match_busy = match_any & ~match_done;

`ifdef LSU_MSHQ_STORE_MERGE_EN
    assign merge_en    = alloc_store & match_busy;
    assign store_block = 1'b0;
`else
    // One store per entry: a second store to a live line waits until the entry frees
    assign merge_en    = 1'b0;
    assign store_block = alloc_store & match_busy;
`endif

    assign alloc_new   = bus.i_alloc_en & ~match_any & has_free;
    assign bus.o_full  = ~has_free;
    assign bus.o_retry = bus.i_alloc_en & (match_done | (~match_any & ~has_free) | store_block);

    tag_t req_idx;
    logic req_fire;

    assign req_idx             = req_hold ? req_hold_idx : pend_idx;
    assign bus.o_mem_req_valid = req_hold | has_pend;
    assign bus.o_mem_req_addr  = bus.o_mem_req_valid ? e_addr[req_idx] : '0;
    assign bus.o_mem_req_tag   = req_idx;
    assign req_fire            = bus.o_mem_req_valid & bus.i_mem_req_ready;

    logic              fill_hit;
    logic              fill_merge_here;
    logic [LINE_W-1:0] fill_line;
    logic [LINE_W-1:0] fill_final;

    assign fill_hit        = bus.i_mem_fill_valid & (e_state[bus.i_mem_fill_tag] == ST_INFLT);
    assign fill_merge_here = merge_en & (match_idx == bus.i_mem_fill_tag);
    assign fill_line       = byte_merge(bus.i_mem_fill_data, e_data[bus.i_mem_fill_tag],
                                        e_mask[bus.i_mem_fill_tag]);
    assign fill_final      = fill_merge_here ? byte_merge(fill_line, st_data, st_mask) : fill_line;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < MSHQ_DEPTH; i++) begin
                e_state[i] <= ST_FREE;
                e_addr[i]  <= '0;
                e_data[i]  <= '0;
                e_mask[i]  <= '0;
                e_dirty[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < MSHQ_DEPTH; i++) begin
                if ((e_state[i] == ST_PEND || e_state[i] == ST_INFLT) && merge_en
                    && match_idx == tag_t'(i)) begin
                    e_data[i]  <= byte_merge(e_data[i], st_data, st_mask);
                    e_mask[i]  <= e_mask[i] | st_mask;
                    e_dirty[i] <= 1'b1;
                end
                case (e_state[i])
                    ST_FREE: begin
                        if (alloc_new && free_idx == tag_t'(i)) begin
                            e_state[i] <= ST_PEND;
                            e_addr[i]  <= line_addr;
                            e_data[i]  <= st_data;
                            e_mask[i]  <= st_mask;
                            e_dirty[i] <= alloc_store;
                        end
                    end
                    ST_PEND: begin
                        if (req_fire && req_idx == tag_t'(i)) e_state[i] <= ST_INFLT;
                    end
                    ST_INFLT: begin
                        if (fill_hit && bus.i_mem_fill_tag == tag_t'(i)) begin
                            e_state[i] <= ST_DONE;
                            e_data[i]  <= fill_final;
                        end
                    end
                    default: e_state[i] <= ST_FREE;
                endcase
            end
        end
    end

    // D$ write is registered straight from the fill path; the entry sits DONE while it is on the bus
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.o_fill_en    <= 1'b0;
            bus.o_fill_addr  <= '0;
            bus.o_fill_data  <= '0;
            bus.o_fill_dirty <= 1'b0;
            req_hold         <= 1'b0;
            req_hold_idx     <= '0;
        end else begin
            bus.o_fill_en <= fill_hit;
            if (fill_hit) begin
                bus.o_fill_addr  <= e_addr[bus.i_mem_fill_tag];
                bus.o_fill_data  <= fill_final;
                bus.o_fill_dirty <= e_dirty[bus.i_mem_fill_tag] | fill_merge_here;
            end
            req_hold     <= bus.o_mem_req_valid & ~bus.i_mem_req_ready;
            req_hold_idx <= req_idx;
        end
    end

endmodule

// File: tb/tb_lsu_mshq.sv
// Scoreboard bench for lsu_mshq: directed scenarios plus random traffic against a line-level model.
module tb_lsu_mshq;

    localparam int DW = 32, AW = 32, LS = 32, DEPTH = 4, TW = 2, LW = LS * 8;
    localparam int M_FREE = 0, M_PEND = 1, M_INFLT = 2, M_DONE = 3;
`ifdef LSU_MSHQ_STORE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    lsu_mshq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DC_LINE_SIZE(LS), .MSHQ_TAG_WIDTH(TW)) bus ();

    lsu_mshq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DC_LINE_SIZE(LS), .MSHQ_DEPTH(DEPTH),
               .MSHQ_TAG_WIDTH(TW)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    typedef struct { logic [31:0] addr; int tag; } req_exp_t;
    typedef struct { logic [31:0] addr; logic [LW-1:0] data; bit dirty; } fill_exp_t;

    req_exp_t  req_q[$];
    fill_exp_t fill_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: one record per queue slot, line bytes kept as a byte array
    int          ms[DEPTH];
    logic [31:0] mline[DEPTH];
    logic [7:0]  mdat[DEPTH][LS];
    bit          mmask[DEPTH][LS];
    bit          mdirty[DEPTH];
    bit          mhold;
    int          mhold_slot;

    bit          s_en, s_st, s_rdy, s_fv;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_w;
    int          s_ftag;
    logic [LW-1:0] s_fdat;
    bit          last_retry;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        s_en = 0; s_st = 0; s_rdy = 0; s_fv = 0;
        s_addr = '0; s_data = '0; s_w = '0; s_ftag = 0; s_fdat = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ms[i] = M_FREE;
        mhold = 0;
        mhold_slot = 0;
    endtask

    function automatic bit model_idle();
        for (int i = 0; i < DEPTH; i++) if (ms[i] != M_FREE) return 0;
        return 1;
    endfunction

    function automatic int pick_inflt();
        int c[$];
        for (int i = 0; i < DEPTH; i++) if (ms[i] == M_INFLT) c.push_back(i);
        if (c.size() == 0) return -1;
        return c[$urandom_range(c.size() - 1)];
    endfunction

    function automatic int slot_of(input logic [31:0] line);
        for (int i = 0; i < DEPTH; i++) if (ms[i] != M_FREE && mline[i] == line) return i;
        return 0;
    endfunction

    // One clock: drive stimulus, check combinational outputs, advance the model past the edge
    task automatic step();
        logic [31:0] line;
        int woff, match, freei, rslot, slot;
        bit exp_retry, merge, alloc, fhit, exp_vld;
        fill_exp_t fe;
        @(posedge clk);
        #1;
        bus.i_alloc_en       = s_en;
        bus.i_alloc_store    = s_st;
        bus.i_alloc_addr     = s_addr;
        bus.i_alloc_data     = s_data;
        bus.i_alloc_width    = s_w;
        bus.i_mem_req_ready  = s_rdy;
        bus.i_mem_fill_valid = s_fv;
        bus.i_mem_fill_tag   = s_ftag[TW-1:0];
        bus.i_mem_fill_data  = s_fdat;
        #1;
        line = s_addr & 32'hFFFF_FFE0;
        woff = int'(s_addr[4:2]) * 4;
        match = -1;
        freei = -1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ms[i] != M_FREE && mline[i] == line) match = i;
            if (ms[i] == M_FREE) freei = i;
        end
        exp_retry = 0; merge = 0; alloc = 0;
        if (s_en) begin
            if (match >= 0) begin
                if (ms[match] == M_DONE) exp_retry = 1;
                else if (s_st) begin
                    if (MERGE) merge = 1;
                    else exp_retry = 1;
                end
            end else if (freei < 0) exp_retry = 1;
            else alloc = 1;
        end
        rslot = -1;
        if (mhold) rslot = mhold_slot;
        else for (int i = DEPTH - 1; i >= 0; i--) if (ms[i] == M_PEND) rslot = i;
        exp_vld = (rslot >= 0);
        chk("full", bus.o_full, freei < 0);
        chk("retry", bus.o_retry, exp_retry);
        chk("req_valid", bus.o_mem_req_valid, exp_vld);
        if (exp_vld) begin
            chk("req_tag_now", bus.o_mem_req_tag, rslot);
            chk("req_addr_now", bus.o_mem_req_addr, mline[rslot]);
            if (s_rdy) req_q.push_back('{mline[rslot], rslot});
        end
        fhit = s_fv && ms[s_ftag] == M_INFLT;
        for (int i = 0; i < DEPTH; i++) if (ms[i] == M_DONE) ms[i] = M_FREE;
        if (exp_vld && s_rdy) ms[rslot] = M_INFLT;
        if (fhit)
            for (int b = 0; b < LS; b++)
                if (!mmask[s_ftag][b]) mdat[s_ftag][b] = s_fdat[8*b +: 8];
        if (merge || alloc) begin
            slot = merge ? match : freei;
            if (alloc) begin
                ms[slot] = M_PEND;
                mline[slot] = line;
                mdirty[slot] = s_st;
                for (int b = 0; b < LS; b++) begin
                    mdat[slot][b] = 8'h00;
                    mmask[slot][b] = 0;
                end
            end
            if (s_st) begin
                mdirty[slot] = 1;
                for (int k = 0; k < 4; k++)
                    if (s_w[k]) begin
                        mdat[slot][woff + k] = s_data[8*k +: 8];
                        mmask[slot][woff + k] = 1;
                    end
            end
        end
        if (fhit) begin
            fe.addr = mline[s_ftag];
            fe.dirty = mdirty[s_ftag];
            for (int b = 0; b < LS; b++) fe.data[8*b +: 8] = mdat[s_ftag][b];
            fill_q.push_back(fe);
            ms[s_ftag] = M_DONE;
        end
        mhold = exp_vld && !s_rdy;
        mhold_slot = rslot;
        last_retry = exp_retry;
    endtask

    task automatic drain();
        int n;
        int t;
        n = 0;
        while (n < 100 && !model_idle()) begin
            clr();
            s_rdy = 1;
            t = pick_inflt();
            if (t >= 0) begin
                s_fv = 1; s_ftag = t; s_fdat = {8{$urandom}};
            end
            step();
            n++;
        end
        checks++;
        if (!model_idle()) begin
            errors++;
            $display("FAIL drain_timeout: queue still busy after %0d cycles", n);
        end
        clr();
        step();
        step();
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a transfer
    initial begin
        req_exp_t  re;
        fill_exp_t fe;
        forever begin
            @(negedge clk);
            if (bus.o_mem_req_valid && bus.i_mem_req_ready) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: tag %0d addr %h with nothing expected",
                             bus.o_mem_req_tag, bus.o_mem_req_addr);
                end else begin
                    re = req_q.pop_front();
                    chk("req_addr", bus.o_mem_req_addr, re.addr);
                    chk("req_tag", bus.o_mem_req_tag, re.tag);
                end
            end
            if (bus.o_fill_en) begin
                if (fill_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fill_unexpected: addr %h with nothing expected", bus.o_fill_addr);
                end else begin
                    fe = fill_q.pop_front();
                    chk("fill_addr", bus.o_fill_addr, fe.addr);
                    chk("fill_data", bus.o_fill_data, fe.data);
                    chk("fill_dirty", bus.o_fill_dirty, fe.dirty);
                end
            end
        end
    end

    initial begin
        logic [LW-1:0] t1_exp;
        int t;
        n_rst = 0;
        clr();
        model_reset();
        bus.i_alloc_en = 0; bus.i_alloc_store = 0; bus.i_alloc_addr = '0; bus.i_alloc_data = '0;
        bus.i_alloc_width = '0; bus.i_mem_req_ready = 0; bus.i_mem_fill_valid = 0;
        bus.i_mem_fill_tag = '0; bus.i_mem_fill_data = '0;
        #12;
        chk("rst_full", bus.o_full, 0);
        chk("rst_retry", bus.o_retry, 0);
        chk("rst_req_valid", bus.o_mem_req_valid, 0);
        chk("rst_fill_en", bus.o_fill_en, 0);
        chk("rst_fill_addr", bus.o_fill_addr, 0);
        chk("rst_fill_data", bus.o_fill_data, 0);
        chk("rst_fill_dirty", bus.o_fill_dirty, 0);
        @(negedge clk);
        n_rst = 1;

        // Store miss merged over a fill of 0x11
        clr(); s_en = 1; s_st = 1; s_addr = 32'h1004; s_data = 32'hAABBCCDD; s_w = 4'hF; step();
        clr(); s_rdy = 1; step();
        clr(); s_fv = 1; s_ftag = 0; s_fdat = {32{8'h11}}; step();
        clr(); step();
        t1_exp = {{24{8'h11}}, 32'hAABBCCDD, 32'h11111111};
        chk("t1_fill_en", bus.o_fill_en, 1);
        chk("t1_fill_data", bus.o_fill_data, t1_exp);
        chk("t1_fill_dirty", bus.o_fill_dirty, 1);
        chk("t1_fill_addr", bus.o_fill_addr, 32'h1000);

        // Second store to an in-flight line
        clr(); s_en = 1; s_st = 1; s_addr = 32'h2000; s_data = 32'h000000EE; s_w = 4'h1; step();
        clr(); s_rdy = 1; step();
        t = slot_of(32'h2000);
        clr(); s_en = 1; s_st = 1; s_addr = 32'h2000; s_data = 32'h000000FF; s_w = 4'h3; step();
        if (last_retry) begin
            for (int n = 0; n < 8 && last_retry; n++) begin
                clr(); s_en = 1; s_st = 1; s_addr = 32'h2000; s_data = 32'h000000FF; s_w = 4'h3;
                s_rdy = 1;
                if (n == 0) begin s_fv = 1; s_ftag = t; s_fdat = {8{$urandom}}; end
                step();
            end
            chk("t2_retry_released", last_retry, 0);
        end else begin
            clr(); s_fv = 1; s_ftag = t; s_fdat = {8{$urandom}}; step();
            clr(); step();
            chk("t2_merged_bytes", bus.o_fill_data[15:0], 16'h00FF);
        end
        drain();

        // Fill the queue with memory stalled, then overflow it
        for (int i = 0; i < 4; i++) begin
            clr(); s_en = 1; s_st = (i == 0); s_addr = 32'h4000 + 32'h1000 * i; s_data = $urandom;
            s_w = 4'hF; step();
        end
        clr(); s_en = 1; s_addr = 32'h8000; step();
        chk("t3_overflow_retry", bus.o_retry, 1);
        clr(); step();
        clr(); step();
        for (int i = 0; i < 4; i++) begin clr(); s_rdy = 1; step(); end

        // Store merge racing the fill of entry 2
        clr(); s_en = 1; s_st = 1; s_addr = 32'h6010; s_data = $urandom; s_w = 4'hF;
        s_fv = 1; s_ftag = 2; s_fdat = {8{$urandom}}; step();
        drain();

        // Allocate against a line that is being written to the D$
        clr(); s_en = 1; s_addr = 32'h3000; step();
        clr(); s_rdy = 1; step();
        clr(); s_fv = 1; s_ftag = slot_of(32'h3000); s_fdat = {8{$urandom}}; step();
        clr(); s_en = 1; s_addr = 32'h3008; step();
        chk("t5_done_retry", bus.o_retry, 1);
        clr(); s_en = 1; s_addr = 32'h3008; step();
        chk("t5_realloc", bus.o_retry, 0);
        drain();

        // Random traffic over six lines so merges, overflows and races all occur
        for (int c = 0; c < 1500; c++) begin
            clr();
            s_en = ($urandom_range(2) != 0);
            s_st = $urandom_range(1);
            s_addr = 32'h1000 * (1 + $urandom_range(5)) + $urandom_range(31);
            s_data = $urandom;
            s_w = 4'($urandom_range(15));
            s_rdy = $urandom_range(1);
            if ($urandom_range(3) == 0) begin
                s_fv = 1; s_ftag = $urandom_range(DEPTH - 1); s_fdat = {8{$urandom}};
            end else begin
                t = pick_inflt();
                if (t >= 0 && $urandom_range(1) == 1) begin
                    s_fv = 1; s_ftag = t; s_fdat = {8{$urandom}};
                end
            end
            step();
        end
        drain();

        // Reset with two fills outstanding; a late fill must be dropped
        clr(); s_en = 1; s_addr = 32'h9000; step();
        clr(); s_en = 1; s_addr = 32'hA000; s_rdy = 1; step();
        clr(); s_rdy = 1; step();
        clr(); step();
        @(posedge clk);
        #1;
        n_rst = 0;
        bus.i_alloc_en = 0; bus.i_mem_req_ready = 0; bus.i_mem_fill_valid = 0;
        model_reset();
        #2;
        chk("mid_rst_full", bus.o_full, 0);
        chk("mid_rst_req_valid", bus.o_mem_req_valid, 0);
        chk("mid_rst_fill_en", bus.o_fill_en, 0);
        @(posedge clk);
        #1;
        n_rst = 1;
        clr(); s_fv = 1; s_ftag = 1; s_fdat = {8{$urandom}}; step();
        clr(); step();
        chk("late_fill_en", bus.o_fill_en, 0);
        chk("late_fill_full", bus.o_full, 0);
        clr(); step();

        checks++;
        if (req_q.size() != 0 || fill_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d requests and %0d fills never seen",
                     req_q.size(), fill_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
